// File: rtl/bpfvm_run_sched.sv
// Run scheduler for the BPF VM: gates program load, packet run and verdict
// handoff around one CPU controller, with a per-packet RUN-cycle watchdog.
module bpfvm_run_sched #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ready,
    input  logic              accept,
    input  logic              reject,
    input  logic              prog_wr_req,
    output logic              prog_wr_gnt,
    output logic              cpu_rst,
    output logic              verdict_valid,
    input  logic              verdict_ready,
    output logic              verdict_accept,
    output logic              verdict_timeout,
    output logic [15:0]       run_cycles,
    output logic [STAT_W-1:0] accept_cnt,
    output logic [STAT_W-1:0] reject_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    localparam logic [15:0]       TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0]       TO_VAL  = 16'(TIMEOUT);
    localparam logic [STAT_W-1:0] SAT     = '1;

    state_t            state_q, state_d;
    logic [15:0]       run_cnt_q, run_cnt_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              gnt_q, gnt_d;
    logic              valid_q, valid_d;
    logic              vacc_q, vacc_d;
    logic              vto_q, vto_d;
    logic [15:0]       rcyc_q, rcyc_d;
    logic [STAT_W-1:0] acnt_q, acnt_d;
    logic [STAT_W-1:0] rcnt_q, rcnt_d;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        vacc_d    = vacc_q;
        vto_d     = vto_q;
        rcyc_d    = rcyc_q;
        acnt_d    = acnt_q;
        rcnt_d    = rcnt_q;
        unique case (state_q)
            IDLE: begin
                if (prog_wr_req) begin
                    state_d = LOAD;
                end else if (mem_ready) begin
                    state_d   = RUN;
                    run_cnt_d = '0;
                end
            end
            LOAD: begin
                if (!prog_wr_req) state_d = IDLE;
            end
            RUN: begin
                run_cnt_d = run_cnt_q + 16'd1;
                // A real verdict beats the watchdog in the same cycle
                if (accept || reject) begin
                    state_d = HOLD;
                    vacc_d  = accept;
                    vto_d   = 1'b0;
                    rcyc_d  = run_cnt_q + 16'd1;
                end else if (run_cnt_q == TO_LAST) begin
                    state_d = HOLD;
                    vacc_d  = 1'b0;
                    vto_d   = 1'b1;
                    rcyc_d  = TO_VAL;
                end
            end
            HOLD: begin
                if (verdict_ready) begin
                    state_d = IDLE;
                    if (vacc_q) begin
                        acnt_d = (acnt_q == SAT) ? acnt_q : acnt_q + STAT_W'(1);
                    end else begin
                        rcnt_d = (rcnt_q == SAT) ? rcnt_q : rcnt_q + STAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cpu_rst_d = (state_d != RUN);
        gnt_d     = (state_d == LOAD);
        valid_d   = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
            cpu_rst_q <= 1'b1;
            gnt_q     <= 1'b0;
            valid_q   <= 1'b0;
            vacc_q    <= 1'b0;
            vto_q     <= 1'b0;
            rcyc_q    <= '0;
            acnt_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            cpu_rst_q <= cpu_rst_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            vacc_q    <= vacc_d;
            vto_q     <= vto_d;
            rcyc_q    <= rcyc_d;
            acnt_q    <= acnt_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign prog_wr_gnt     = gnt_q;
    assign cpu_rst         = cpu_rst_q;
    assign verdict_valid   = valid_q;
    assign verdict_accept  = vacc_q;
    assign verdict_timeout = vto_q;
    assign run_cycles      = rcyc_q;
    assign accept_cnt      = acnt_q;
    assign reject_cnt      = rcnt_q;

endmodule

// File: tb/tb_bpfvm_run_sched.sv
// Bench for bpfvm_run_sched: directed scenarios plus random packet traffic
// checked against a packet-level model of run length, verdict and statistics.
module tb_bpfvm_run_sched;

    localparam int TO   = 8;
    localparam int SW   = 4;
    localparam int SATV = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_ready = 1'b0;
    logic          accept = 1'b0;
    logic          reject = 1'b0;
    logic          prog_wr_req = 1'b0;
    logic          verdict_ready = 1'b0;
    logic          prog_wr_gnt;
    logic          cpu_rst;
    logic          verdict_valid;
    logic          verdict_accept;
    logic          verdict_timeout;
    logic [15:0]   run_cycles;
    logic [SW-1:0] accept_cnt;
    logic [SW-1:0] reject_cnt;

    int n_chk = 0;
    int n_err = 0;
    int m_acc = 0;
    int m_rej = 0;

    always #5 clk = ~clk;

    bpfvm_run_sched #(.TIMEOUT(TO), .STAT_W(SW)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_ready       (mem_ready),
        .accept          (accept),
        .reject          (reject),
        .prog_wr_req     (prog_wr_req),
        .prog_wr_gnt     (prog_wr_gnt),
        .cpu_rst         (cpu_rst),
        .verdict_valid   (verdict_valid),
        .verdict_ready   (verdict_ready),
        .verdict_accept  (verdict_accept),
        .verdict_timeout (verdict_timeout),
        .run_cycles      (run_cycles),
        .accept_cnt      (accept_cnt),
        .reject_cnt      (reject_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_cnt();
        check("accept_cnt", 32'(accept_cnt), 32'(m_acc));
        check("reject_cnt", 32'(reject_cnt), 32'(m_rej));
    endtask

    task automatic check_rst_vals();
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_gnt", 32'(prog_wr_gnt), 32'd0);
        check("rst_valid", 32'(verdict_valid), 32'd0);
        check("rst_vacc", 32'(verdict_accept), 32'd0);
        check("rst_vto", 32'(verdict_timeout), 32'd0);
        check("rst_rcyc", 32'(run_cycles), 32'd0);
        check_cnt();
    endtask

    // Reset wipes statistics; an aborted packet must not count.
    task automatic rst_pulse();
        rst = 1'b1;
        accept = 1'b0;
        reject = 1'b0;
        mem_ready = 1'b0;
        prog_wr_req = 1'b0;
        verdict_ready = 1'b0;
        @(negedge clk);
        m_acc = 0;
        m_rej = 0;
        check_rst_vals();
        rst = 1'b0;
        @(negedge clk);
        check("no_run_after_rst", 32'(cpu_rst), 32'd1);
    endtask

    // Called just after the negedge of RUN cycle 1.
    task automatic run_body(input int k, input bit acc, input bit rej,
                            input int d, input int ab_at, input bit ab_hold);
        bit has_v;
        bit exp_to;
        int exp_n;
        int cyc;
        has_v  = (acc || rej) && (k <= TO);
        exp_to = !has_v;
        exp_n  = has_v ? k : TO;
        cyc    = 0;
        while (cpu_rst === 1'b0 && cyc < 64) begin
            cyc++;
            if (cyc == ab_at) begin
                rst_pulse();
                return;
            end
            accept = (cyc == k) ? acc : 1'b0;
            reject = (cyc == k) ? rej : 1'b0;
            @(negedge clk);
        end
        accept = 1'b0;
        reject = 1'b0;
        check("run_len", 32'(cyc), 32'(exp_n));
        check("valid_rise", 32'(verdict_valid), 32'd1);
        check("vacc", 32'(verdict_accept), 32'(!exp_to && acc));
        check("vto", 32'(verdict_timeout), 32'(exp_to));
        check("rcyc", 32'(run_cycles), 32'(exp_n));
        for (int i = 0; i < d; i++) begin
            mem_ready = 1'b1;
            prog_wr_req = 1'($urandom);
            accept = 1'($urandom);
            reject = 1'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(verdict_valid), 32'd1);
            check("hold_vacc", 32'(verdict_accept), 32'(!exp_to && acc));
            check("hold_vto", 32'(verdict_timeout), 32'(exp_to));
            check("hold_rcyc", 32'(run_cycles), 32'(exp_n));
            check("hold_gnt", 32'(prog_wr_gnt), 32'd0);
            check("hold_cpu_rst", 32'(cpu_rst), 32'd1);
        end
        if (ab_hold) begin
            rst_pulse();
            return;
        end
        verdict_ready = 1'b1;
        mem_ready = 1'b0;
        prog_wr_req = 1'b0;
        accept = 1'b0;
        reject = 1'b0;
        @(negedge clk);
        verdict_ready = 1'b0;
        if (!exp_to && acc) m_acc = (m_acc == SATV) ? SATV : m_acc + 1;
        else m_rej = (m_rej == SATV) ? SATV : m_rej + 1;
        check("valid_drop", 32'(verdict_valid), 32'd0);
        check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
        check_cnt();
    endtask

    // Stray verdicts and an early ready in IDLE must be harmless.
    task automatic run_pkt(input int k, input bit acc, input bit rej,
                           input int d, input int ab_at, input bit ab_hold);
        mem_ready = 1'b1;
        verdict_ready = 1'($urandom);
        accept = 1'($urandom);
        reject = 1'($urandom);
        @(negedge clk);
        mem_ready = 1'b0;
        verdict_ready = 1'b0;
        accept = 1'b0;
        reject = 1'b0;
        run_body(k, acc, rej, d, ab_at, ab_hold);
    endtask

    task automatic do_load(input int len, input bit with_mem, input int k,
                           input bit acc, input bit rej);
        prog_wr_req = 1'b1;
        mem_ready = with_mem;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check("load_gnt", 32'(prog_wr_gnt), 32'd1);
            check("load_cpu_rst", 32'(cpu_rst), 32'd1);
        end
        prog_wr_req = 1'b0;
        @(negedge clk);
        check("load_gnt_drop", 32'(prog_wr_gnt), 32'd0);
        check("load_idle_cpu_rst", 32'(cpu_rst), 32'd1);
        if (with_mem) begin
            @(negedge clk);
            mem_ready = 1'b0;
            run_body(k, acc, rej, 0, 0, 1'b0);
        end else begin
            mem_ready = 1'b0;
        end
    endtask

    initial begin
        int k;
        int lim;
        @(negedge clk);
        rst_pulse();
        run_pkt(3, 1'b1, 1'b0, 0, 0, 1'b0);
        run_pkt(20, 1'b0, 1'b0, 0, 0, 1'b0);
        run_pkt(2, 1'b1, 1'b1, 1, 0, 1'b0);
        run_pkt(TO, 1'b0, 1'b1, 0, 0, 1'b0);
        run_pkt(TO, 1'b1, 1'b0, 0, 0, 1'b0);
        do_load(3, 1'b1, 2, 1'b0, 1'b1);
        do_load(2, 1'b0, 0, 1'b0, 1'b0);
        run_pkt(4, 1'b1, 1'b0, 10, 0, 1'b0);
        run_pkt(20, 1'b0, 1'b0, 0, 3, 1'b0);
        run_pkt(2, 1'b0, 1'b1, 2, 0, 1'b1);
        for (int i = 0; i < 18; i++) run_pkt(1, 1'b0, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 18; i++) run_pkt(2, 1'b1, 1'b0, 0, 0, 1'b0);
        rst_pulse();
        for (int i = 0; i < 200; i++) begin
            int op;
            bit acc;
            bit rej;
            op  = $urandom_range(0, 9);
            k   = $urandom_range(1, TO + 3);
            acc = 1'($urandom);
            rej = 1'($urandom);
            lim = (k < TO) ? k : TO;
            if (op == 0) begin
                do_load($urandom_range(1, 4), 1'($urandom), k, acc, rej);
            end else if (op == 1) begin
                if ($urandom_range(0, 1) == 0)
                    run_pkt(k, acc, rej, 0, $urandom_range(1, lim), 1'b0);
                else
                    run_pkt(k, acc, rej, $urandom_range(0, 3), 0, 1'b1);
            end else begin
                run_pkt(k, acc, rej, $urandom_range(0, 3), 0, 1'b0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
